// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Registered ALU operands, one-cycle EXEC, result returned over per-requester valid/ready.
module alu_share_arbiter #(
   parameter int W     = 32,
   parameter int FUN_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_a,
   input  logic [W-1:0]     req0_b,
   input  logic [FUN_W-1:0] req0_fun,
   input  logic             req0_sign,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_a,
   input  logic [W-1:0]     req1_b,
   input  logic [FUN_W-1:0] req1_fun,
   input  logic             req1_sign,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [W-1:0]     rsp0_z,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [W-1:0]     rsp1_z,
   output logic             rsp1_err,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [FUN_W-1:0] alu_fun,
   output logic             alu_sign,
   input  logic [W-1:0]     alu_z,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [W-1:0]     alu_a_q, alu_a_d;
   logic [W-1:0]     alu_b_q, alu_b_d;
   logic [FUN_W-1:0] alu_fun_q, alu_fun_d;
   logic             alu_sign_q, alu_sign_d;
   logic [W-1:0]     res_q, res_d;
   logic             err_q, err_d;

   logic             gnt0, gnt1, accept, sel;
   logic [W-1:0]     sel_a, sel_b;
   logic [FUN_W-1:0] sel_fun;
   logic             sel_sign;

   // Decodes exactly the ALUFun codes the shared ALU implements.
   function automatic logic fun_legal(input logic [FUN_W-1:0] f);
      logic ok;
      case (f[5:4])
         2'b00:   ok = (f[3:1] == 3'b000);
         2'b01:   ok = (f[3:0] == 4'b1000) || (f[3:0] == 4'b1110) || (f[3:0] == 4'b0110) ||
                       (f[3:0] == 4'b0001) || (f[3:0] == 4'b1010);
         2'b10:   ok = (f[3:2] == 2'b00) && (f[1:0] != 2'b10);
         default: ok = (f[3:1] != 3'b011) && (f[3:1] != 3'b100);
      endcase
      return ok;
   endfunction

   always_comb begin
      gnt0     = (state_q == IDLE) && req0_valid && (!req1_valid || !ptr_q);
      gnt1     = (state_q == IDLE) && req1_valid && (!req0_valid || ptr_q);
      accept   = gnt0 || gnt1;
      sel      = gnt1;
      sel_a    = sel ? req1_a    : req0_a;
      sel_b    = sel ? req1_b    : req0_b;
      sel_fun  = sel ? req1_fun  : req0_fun;
      sel_sign = sel ? req1_sign : req0_sign;
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_fun_d  = alu_fun_q;
      alu_sign_d = alu_sign_q;
      res_d      = res_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = sel;
               ptr_d   = ~sel;
               if (fun_legal(sel_fun)) begin
                  alu_a_d    = sel_a;
                  alu_b_d    = sel_b;
                  alu_fun_d  = sel_fun;
                  alu_sign_d = sel_sign;
                  state_d    = EXEC;
               end else begin
                  // Rejected ops never reach the ALU; respond with an error straight away.
                  res_d   = '0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         EXEC: begin
            res_d   = alu_z;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         owner_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_fun_q  <= '0;
         alu_sign_q <= 1'b0;
         res_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_fun_q  <= alu_fun_d;
         alu_sign_q <= alu_sign_d;
         res_q      <= res_d;
         err_q      <= err_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp0_valid = (state_q == RESP) && !owner_q;
   assign rsp1_valid = (state_q == RESP) && owner_q;
   assign rsp0_z     = res_q;
   assign rsp1_z     = res_q;
   assign rsp0_err   = err_q;
   assign rsp1_err   = err_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_fun    = alu_fun_q;
   assign alu_sign   = alu_sign_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
// Directed vector table, hand-written corner sequences, then randomized traffic against a model.
module tb_alu_share_arbiter;

   logic        clk, reset;
   logic        req0_valid, req0_ready, req0_sign;
   logic [31:0] req0_a, req0_b;
   logic [5:0]  req0_fun;
   logic        req1_valid, req1_ready, req1_sign;
   logic [31:0] req1_a, req1_b;
   logic [5:0]  req1_fun;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic [31:0] rsp0_z;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [31:0] rsp1_z;
   logic [31:0] alu_a, alu_b, alu_z;
   logic [5:0]  alu_fun;
   logic        alu_sign, busy;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.W(32), .FUN_W(6)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_fun(req0_fun), .req0_sign(req0_sign),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_fun(req1_fun), .req1_sign(req1_sign),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_err(rsp1_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign), .alu_z(alu_z),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU standing in for the shared unit.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic s);
      logic [31:0] r;
      r = 32'd0;
      case (f[5:4])
         2'b00: r = f[0] ? a - b : a + b;
         2'b01: case (f[3:0])
                   4'b1000: r = a & b;
                   4'b1110: r = a | b;
                   4'b0110: r = a ^ b;
                   4'b0001: r = ~(a | b);
                   4'b1010: r = a;
                   default: r = 32'd0;
                endcase
         2'b10: case (f[1:0])
                   2'b00:   r = b << a[4:0];
                   2'b01:   r = b >> a[4:0];
                   2'b11:   r = $signed(b) >>> a[4:0];
                   default: r = 32'd0;
                endcase
         default: case (f[3:1])
                   3'b000:  r = {31'd0, a != b};
                   3'b001:  r = {31'd0, a == b};
                   3'b010:  r = {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
                   3'b110:  r = {31'd0, $signed(a) <= 0};
                   3'b101:  r = {31'd0, $signed(a) < 0};
                   3'b111:  r = {31'd0, $signed(a) > 0};
                   default: r = 32'd0;
                endcase
      endcase
      return r;
   endfunction

   assign alu_z = alu_fn(alu_a, alu_b, alu_fun, alu_sign);

   logic [5:0] legal_list [22];

   function automatic bit is_legal(input logic [5:0] f);
      for (int i = 0; i < 22; i++) if (legal_list[i] == f) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic s);
      if (r == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_fun = f; req0_sign = s;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_fun = f; req1_sign = s;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   typedef struct {
      int          req;
      logic [31:0] a, b;
      logic [5:0]  fun;
      logic        sign;
      logic [31:0] z;
      logic        err;
   } vec_t;

   // One op on a single requester with rsp_ready high: accept at T, EXEC at T+1, response at T+2.
   task automatic run_op(input vec_t v);
      logic [31:0] pa, pb;
      logic [5:0]  pf;
      logic        rv, ov, re;
      logic [31:0] rz;
      pa = alu_a; pb = alu_b; pf = alu_fun;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req(v.req, 1'b1, v.a, v.b, v.fun, v.sign);
      #1;
      check1("vec_ready", (v.req == 0) ? req0_ready : req1_ready, 1'b1);
      check1("vec_other_ready", (v.req == 0) ? req1_ready : req0_ready, 1'b0);
      step();
      set_req(v.req, 1'b0, v.a, v.b, v.fun, v.sign);
      if (!v.err) begin
         check1("vec_exec_busy", busy, 1'b1);
         check32("vec_alu_a", alu_a, v.a);
         check32("vec_alu_b", alu_b, v.b);
         check32("vec_alu_fun", {26'd0, alu_fun}, {26'd0, v.fun});
         check1("vec_exec_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
         step();
      end else begin
         check32("vec_illegal_alu_a_held", alu_a, pa);
         check32("vec_illegal_alu_b_held", alu_b, pb);
         check32("vec_illegal_alu_fun_held", {26'd0, alu_fun}, {26'd0, pf});
      end
      rv = (v.req == 0) ? rsp0_valid : rsp1_valid;
      ov = (v.req == 0) ? rsp1_valid : rsp0_valid;
      rz = (v.req == 0) ? rsp0_z : rsp1_z;
      re = (v.req == 0) ? rsp0_err : rsp1_err;
      check1("vec_rsp_valid", rv, 1'b1);
      check1("vec_rsp_other_valid", ov, 1'b0);
      check32("vec_rsp_z", rz, v.z);
      check1("vec_rsp_err", re, v.err);
      step();
      check1("vec_back_idle", busy, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   vec_t vecs [13];
   int   order [4];
   int   when [4];
   int   n;

   // randomized-phase state
   bit          pend [2];
   logic [31:0] pa [2], pb [2];
   logic [5:0]  pf [2];
   logic        ps [2];
   bit          rr [2];
   bit          m_busy, m_resp, m_last;
   int          m_owner;
   logic [31:0] m_a, m_b, m_z;
   logic [5:0]  m_f;
   logic        m_err;
   logic        e_rdy0, e_rdy1;
   int          idx;

   initial begin
      legal_list = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                     6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110000, 6'b110001,
                     6'b110010, 6'b110011, 6'b110100, 6'b110101, 6'b111010, 6'b111011,
                     6'b111100, 6'b111101, 6'b111110, 6'b111111};
      vecs[0]  = '{0, 32'd5,          32'd7,          6'b000000, 1'b0, 32'd12,         1'b0};
      vecs[1]  = '{0, 32'd4,          32'h00000001,   6'b100000, 1'b0, 32'h00000010,   1'b0};
      vecs[2]  = '{0, 32'hF0F0F0F0,   32'hFF00FF00,   6'b011000, 1'b0, 32'hF000F000,   1'b0};
      vecs[3]  = '{1, 32'd10,         32'd3,          6'b000001, 1'b0, 32'd7,          1'b0};
      vecs[4]  = '{1, 32'h12345678,   32'd0,          6'b000110, 1'b0, 32'd0,          1'b1};
      vecs[5]  = '{0, 32'd4,          32'h80000000,   6'b100011, 1'b0, 32'hF8000000,   1'b0};
      vecs[6]  = '{1, 32'h000000FF,   32'h0000000F,   6'b010110, 1'b0, 32'h000000F0,   1'b0};
      vecs[7]  = '{0, 32'hFFFFFFFF,   32'd1,          6'b110101, 1'b1, 32'd1,          1'b0};
      vecs[8]  = '{0, 32'hFFFFFFFF,   32'd1,          6'b110101, 1'b0, 32'd0,          1'b0};
      vecs[9]  = '{1, 32'd9,          32'd9,          6'b110011, 1'b0, 32'd1,          1'b0};
      vecs[10] = '{0, 32'd1,          32'd2,          6'b111000, 1'b0, 32'd0,          1'b1};
      vecs[11] = '{1, 32'd1,          32'd2,          6'b101000, 1'b0, 32'd0,          1'b1};
      vecs[12] = '{0, 32'd3,          32'd99,         6'b011010, 1'b0, 32'd3,          1'b0};

      reset = 1'b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req(0, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      set_req(1, 1'b0, 32'd0, 32'd0, 6'd0, 1'b0);
      step(); step(); step();
      reset = 1'b0;
      #1;
      check1("rst_busy", busy, 1'b0);
      check1("rst_rsp0_valid", rsp0_valid, 1'b0);
      check1("rst_rsp1_valid", rsp1_valid, 1'b0);
      check1("rst_ready", req0_ready | req1_ready, 1'b0);
      check32("rst_alu_a", alu_a, 32'd0);
      check32("rst_alu_b", alu_b, 32'd0);
      check32("rst_alu_fun", {26'd0, alu_fun}, 32'd0);
      check1("rst_alu_sign", alu_sign, 1'b0);
      check32("rst_rsp_z", rsp0_z | rsp1_z, 32'd0);
      check1("rst_rsp_err", rsp0_err | rsp1_err, 1'b0);

      for (int i = 0; i < 13; i++) run_op(vecs[i]);

      // Contention: both valid from the first post-reset cycle, grants must alternate.
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req(0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 6'b011000, 1'b0);
      set_req(1, 1'b1, 32'd10, 32'd3, 6'b000001, 1'b0);
      for (int i = 0; i < 4; i++) begin order[i] = 9; when[i] = -1; end
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         #1;
         if (req0_ready) begin order[n] = 0; when[n] = c; n++; end
         else if (req1_ready) begin order[n] = 1; when[n] = c; n++; end
         if (rsp0_valid) check32("cont_rsp0_z", rsp0_z, 32'hF000F000);
         if (rsp1_valid) check32("cont_rsp1_z", rsp1_z, 32'd7);
         step();
      end
      check32("cont_accept_count", n, 32'd4);
      check32("cont_first_cycle", when[0], 32'd0);
      check32("cont_second_gap", when[1] - when[0], 32'd3);
      check32("cont_order0", order[0], 32'd0);
      check32("cont_order1", order[1], 32'd1);
      check32("cont_order2", order[2], 32'd0);
      check32("cont_order3", order[3], 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 10 && busy; c++) step();
      check1("cont_drained", busy, 1'b0);

      // Backpressure on requester 0 while requester 1 waits.
      rsp0_ready = 1'b0;
      set_req(0, 1'b1, 32'd5, 32'd7, 6'b000000, 1'b0);
      #1;
      check1("bp_accept", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      set_req(1, 1'b1, 32'd10, 32'd3, 6'b000001, 1'b0);
      step();
      for (int c = 0; c < 4; c++) begin
         check1("bp_rsp0_valid", rsp0_valid, 1'b1);
         check32("bp_rsp0_z", rsp0_z, 32'd12);
         check1("bp_ready_low", req0_ready | req1_ready, 1'b0);
         check1("bp_busy", busy, 1'b1);
         step();
      end
      rsp0_ready = 1'b1;
      step();
      check1("bp_idle_after", busy, 1'b0);
      check1("bp_req1_ready", req1_ready, 1'b1);
      step();
      req1_valid = 1'b0;
      step();
      check1("bp_rsp1_valid", rsp1_valid, 1'b1);
      check32("bp_rsp1_z", rsp1_z, 32'd7);
      step();

      // Reset during EXEC drops the op and restores the pointer.
      set_req(0, 1'b1, 32'd21, 32'd22, 6'b000000, 1'b0);
      #1;
      check1("rmid_accept", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      check1("rmid_in_exec", busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check1("rmid_idle", busy, 1'b0);
      check32("rmid_alu_a", alu_a, 32'd0);
      check32("rmid_alu_b", alu_b, 32'd0);
      check32("rmid_alu_fun", {26'd0, alu_fun}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         check1("rmid_no_rsp0", rsp0_valid, 1'b0);
         step();
      end
      set_req(0, 1'b1, 32'd1, 32'd1, 6'b000000, 1'b0);
      set_req(1, 1'b1, 32'd1, 32'd1, 6'b000000, 1'b0);
      #1;
      check1("rmid_ptr_req0", req0_ready, 1'b1);
      check1("rmid_ptr_req1", req1_ready, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Randomized traffic against a transaction-level model.
      do_reset();
      pend[0] = 0; pend[1] = 0;
      m_busy = 0; m_resp = 0; m_last = 1'b1; m_owner = 0;
      m_a = 0; m_b = 0; m_f = 0; m_z = 0; m_err = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1;
               pa[i] = $urandom;
               pb[i] = $urandom;
               ps[i] = 1'($urandom_range(0, 1));
               idx = int'($urandom_range(0, 21));
               pf[i] = ($urandom_range(0, 3) != 0) ? legal_list[idx] : 6'($urandom_range(0, 63));
            end
            rr[i] = ($urandom_range(0, 3) != 0);
         end
         set_req(0, pend[0], pa[0], pb[0], pf[0], ps[0]);
         set_req(1, pend[1], pa[1], pb[1], pf[1], ps[1]);
         rsp0_ready = rr[0]; rsp1_ready = rr[1];
         #1;
         e_rdy0 = !m_busy && pend[0] && (!pend[1] || m_last);
         e_rdy1 = !m_busy && pend[1] && (!pend[0] || !m_last);
         check1("rnd_req0_ready", req0_ready, e_rdy0);
         check1("rnd_req1_ready", req1_ready, e_rdy1);
         check1("rnd_busy", busy, m_busy);
         check1("rnd_rsp0_valid", rsp0_valid, m_busy && m_resp && m_owner == 0);
         check1("rnd_rsp1_valid", rsp1_valid, m_busy && m_resp && m_owner == 1);
         if (m_busy && m_resp) begin
            check32("rnd_rsp_z", (m_owner == 0) ? rsp0_z : rsp1_z, m_z);
            check1("rnd_rsp_err", (m_owner == 0) ? rsp0_err : rsp1_err, m_err);
         end
         if (m_busy && !m_resp) begin
            check32("rnd_alu_a", alu_a, m_a);
            check32("rnd_alu_b", alu_b, m_b);
            check32("rnd_alu_fun", {26'd0, alu_fun}, {26'd0, m_f});
         end
         step();
         if (e_rdy0 || e_rdy1) begin
            idx = e_rdy1 ? 1 : 0;
            m_last = e_rdy1;
            pend[idx] = 0;
            m_busy = 1;
            m_owner = idx;
            if (is_legal(pf[idx])) begin
               m_resp = 0;
               m_a = pa[idx]; m_b = pb[idx]; m_f = pf[idx];
               m_z = alu_fn(pa[idx], pb[idx], pf[idx], ps[idx]);
               m_err = 0;
            end else begin
               m_resp = 1;
               m_z = 32'd0;
               m_err = 1;
            end
         end else if (m_busy && !m_resp) begin
            m_resp = 1;
         end else if (m_busy && rr[m_owner]) begin
            m_busy = 0;
            m_resp = 0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
